// File: rtl/uivtc_win_ctrl_if.sv
// Host configuration channel for the PIP window controller.
// The host sends a requested position over a valid/ready handshake and gets a done pulse back.
interface uivtc_win_ctrl_if;
  logic        I_cfg_valid;
  logic        O_cfg_ready;
  logic [11:0] I_cfg_x;
  logic [11:0] I_cfg_y;
  logic        I_cfg_mode;
  logic        O_cfg_done;

  modport master (
    output I_cfg_valid, I_cfg_x, I_cfg_y, I_cfg_mode,
    input  O_cfg_ready, O_cfg_done
  );

  modport slave (
    input  I_cfg_valid, I_cfg_x, I_cfg_y, I_cfg_mode,
    output O_cfg_ready, O_cfg_done
  );
endinterface

// File: rtl/uivtc_win_ctrl.sv
// PIP window position sequencer: host requests are clamped into the active area and are
// applied only on a VS rising edge. In bounce mode the window moves automatically, and it moves only on VS rising edges.
module uivtc_win_ctrl #(
  parameter int H_ActiveSize  = 1024,
  parameter int V_ActiveSize  = 600,
  parameter int H2_ActiveSize = 640,
  parameter int V2_ActiveSize = 480,
  parameter int STEP_X        = 2,
  parameter int STEP_Y        = 1,
  parameter int FRAME_DIV     = 1
) (
  input  logic              I_vtc_clk,
  input  logic              I_vtc_rst,
  input  logic              I_vtc_vs,
  uivtc_win_ctrl_if.slave   cfg,
  output logic [11:0]       O_offset_x,
  output logic [11:0]       O_offset_y,
  output logic              O_bounce
);

  localparam logic [12:0] XMAX = (H_ActiveSize > H2_ActiveSize) ?
                                 13'(H_ActiveSize - H2_ActiveSize) : 13'd0;
  localparam logic [12:0] YMAX = (V_ActiveSize > V2_ActiveSize) ?
                                 13'(V_ActiveSize - V2_ActiveSize) : 13'd0;
  localparam logic [12:0] STEPX    = 13'(STEP_X);
  localparam logic [12:0] STEPY    = 13'(STEP_Y);
  localparam logic [15:0] DIV_LAST = 16'(FRAME_DIV - 1);

  typedef enum logic [1:0] {IDLE, PEND, DONE} state_e;

  state_e      state_q;
  logic        ready_q, done_q, bounce_q;
  logic [11:0] offsetX_q, offsetY_q;
  logic [11:0] shadowX_q, shadowY_q;
  logic        shadowMode_q;
  logic        dirXPos_q, dirYPos_q;
  logic [15:0] div_q;
  logic        vsPrev_q, vsArmed_q;

  logic        tick, accept;
  logic [12:0] curX, curY, reqX, reqY, clampX, clampY;
  logic [12:0] moveX_d, moveY_d;
  logic        dirXPos_d, dirYPos_d;

  // vsArmed_q blocks a false tick when VS is already high as reset releases.
  assign tick   = I_vtc_vs & ~vsPrev_q & vsArmed_q;
  assign accept = cfg.I_cfg_valid & ready_q;

  assign curX   = {1'b0, offsetX_q};
  assign curY   = {1'b0, offsetY_q};
  assign reqX   = {1'b0, cfg.I_cfg_x};
  assign reqY   = {1'b0, cfg.I_cfg_y};
  assign clampX = (reqX > XMAX) ? XMAX : reqX;
  assign clampY = (reqY > YMAX) ? YMAX : reqY;

  always_comb begin
    moveX_d   = curX;
    dirXPos_d = dirXPos_q;
    if (dirXPos_q) begin
      if (curX + STEPX >= XMAX) begin
        moveX_d   = XMAX;
        dirXPos_d = 1'b0;
      end else begin
        moveX_d = curX + STEPX;
      end
    end else if (curX <= STEPX) begin
      moveX_d   = '0;
      dirXPos_d = 1'b1;
    end else begin
      moveX_d = curX - STEPX;
    end
  end

  always_comb begin
    moveY_d   = curY;
    dirYPos_d = dirYPos_q;
    if (dirYPos_q) begin
      if (curY + STEPY >= YMAX) begin
        moveY_d   = YMAX;
        dirYPos_d = 1'b0;
      end else begin
        moveY_d = curY + STEPY;
      end
    end else if (curY <= STEPY) begin
      moveY_d   = '0;
      dirYPos_d = 1'b1;
    end else begin
      moveY_d = curY - STEPY;
    end
  end

  always_ff @(posedge I_vtc_clk) begin
    if (I_vtc_rst) begin
      state_q      <= IDLE;
      ready_q      <= 1'b0;
      done_q       <= 1'b0;
      bounce_q     <= 1'b0;
      offsetX_q    <= '0;
      offsetY_q    <= '0;
      shadowX_q    <= '0;
      shadowY_q    <= '0;
      shadowMode_q <= 1'b0;
      dirXPos_q    <= 1'b1;
      dirYPos_q    <= 1'b1;
      div_q        <= '0;
      vsPrev_q     <= 1'b0;
      vsArmed_q    <= ~I_vtc_vs;
    end else begin
      vsPrev_q  <= I_vtc_vs;
      vsArmed_q <= vsArmed_q | ~I_vtc_vs;
      done_q    <= 1'b0;

      // A pending request owns the tick; otherwise bounce runs on the current offsets.
      if (state_q != PEND && bounce_q && tick) begin
        if (div_q == DIV_LAST) begin
          div_q     <= '0;
          offsetX_q <= moveX_d[11:0];
          offsetY_q <= moveY_d[11:0];
          dirXPos_q <= dirXPos_d;
          dirYPos_q <= dirYPos_d;
        end else begin
          div_q <= div_q + 16'd1;
        end
      end

      case (state_q)
        IDLE: begin
          ready_q <= 1'b1;
          if (accept) begin
            shadowX_q    <= clampX[11:0];
            shadowY_q    <= clampY[11:0];
            shadowMode_q <= cfg.I_cfg_mode;
            ready_q      <= 1'b0;
            state_q      <= PEND;
          end
        end
        PEND: begin
          if (tick) begin
            offsetX_q <= shadowX_q;
            offsetY_q <= shadowY_q;
            bounce_q  <= shadowMode_q;
            dirXPos_q <= 1'b1;
            dirYPos_q <= 1'b1;
            div_q     <= '0;
            done_q    <= 1'b1;
            state_q   <= DONE;
          end
        end
        DONE: begin
          ready_q <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cfg.O_cfg_ready = ready_q;
  assign cfg.O_cfg_done  = done_q;
  assign O_offset_x      = offsetX_q;
  assign O_offset_y      = offsetY_q;
  assign O_bounce        = bounce_q;

endmodule

// File: tb/tb_uivtc_win_ctrl.sv
// Bench for uivtc_win_ctrl: a directed vector table, hand-written corner sequences and random traffic,
// all checked against a frame-level reference model, on two instances (FRAME_DIV 1 and 3).
module tb_uivtc_win_ctrl;
  localparam int XMAX = 384;
  localparam int YMAX = 120;

  logic        clk = 1'b0;
  logic        rst, vs, valid, cm;
  logic [11:0] cx, cy;
  logic [11:0] offX0, offY0, offX1, offY1;
  logic        bnc0, bnc1;

  int checks = 0;
  int passes = 0;

  uivtc_win_ctrl_if cfgA ();
  uivtc_win_ctrl_if cfgB ();

  assign cfgA.I_cfg_valid = valid;
  assign cfgA.I_cfg_x     = cx;
  assign cfgA.I_cfg_y     = cy;
  assign cfgA.I_cfg_mode  = cm;
  assign cfgB.I_cfg_valid = valid;
  assign cfgB.I_cfg_x     = cx;
  assign cfgB.I_cfg_y     = cy;
  assign cfgB.I_cfg_mode  = cm;

  uivtc_win_ctrl #(.FRAME_DIV(1)) dut0 (
    .I_vtc_clk(clk), .I_vtc_rst(rst), .I_vtc_vs(vs), .cfg(cfgA.slave),
    .O_offset_x(offX0), .O_offset_y(offY0), .O_bounce(bnc0)
  );

  uivtc_win_ctrl #(.FRAME_DIV(3)) dut1 (
    .I_vtc_clk(clk), .I_vtc_rst(rst), .I_vtc_vs(vs), .cfg(cfgB.slave),
    .O_offset_x(offX1), .O_offset_y(offY1), .O_bounce(bnc1)
  );

  always #5 clk = ~clk;

  // Reference model: window position per instance, advanced once per clock.
  typedef struct {
    int x; int y; int dx; int dy; int div;
    bit bnc; bit rdy; bit dn; bit waiting;
    int px; int py; bit pm;
  } mdl_t;

  mdl_t m[2];
  bit   prevVs = 1'b0;

  typedef struct {
    bit r; bit v; bit va; logic [11:0] x; logic [11:0] y; bit mo;
    bit eRdy; bit eDn; logic [11:0] eX; logic [11:0] eY; bit eB;
  } vec_t;

  vec_t tbl[10];

  function automatic logic [31:0] pk(int r, int d, int b, int x, int y);
    return {5'b0, 1'(r), 1'(d), 1'(b), 12'(x), 12'(y)};
  endfunction

  function automatic logic [31:0] act0();
    return {5'b0, cfgA.O_cfg_ready, cfgA.O_cfg_done, bnc0, offX0, offY0};
  endfunction

  function automatic logic [31:0] act1();
    return {5'b0, cfgB.O_cfg_ready, cfgB.O_cfg_done, bnc1, offX1, offY1};
  endfunction

  function automatic logic [31:0] expOf(int k);
    return {5'b0, m[k].rdy, m[k].dn, m[k].bnc, 12'(m[k].x), 12'(m[k].y)};
  endfunction

  // Reflects a position between 0 and lim; the wall is reached instead of overshot.
  function automatic void moveAxis(inout int pos, inout int dir, input int step, input int lim);
    if (dir > 0) begin
      if (pos + step >= lim) begin pos = lim; dir = -1; end
      else pos = pos + step;
    end else begin
      if (pos <= step) begin pos = 0; dir = 1; end
      else pos = pos - step;
    end
  endfunction

  task automatic modelStep(input bit r, input bit tk, input bit va,
                           input int x, input int y, input bit mo);
    mdl_t o, n;
    int   fd, p, d;
    for (int k = 0; k < 2; k++) begin
      fd = (k == 0) ? 1 : 3;
      if (r) begin
        m[k] = '{default: 0};
        m[k].dx = 1;
        m[k].dy = 1;
      end else begin
        o = m[k];
        n = o;
        n.dn = 1'b0;
        if (o.waiting) begin
          if (tk) begin
            n.x = o.px; n.y = o.py; n.bnc = o.pm;
            n.dx = 1; n.dy = 1; n.div = 0;
            n.waiting = 1'b0; n.dn = 1'b1;
          end
        end else begin
          if (o.bnc && tk) begin
            if (o.div == fd - 1) begin
              p = n.x; d = n.dx; moveAxis(p, d, 2, XMAX); n.x = p; n.dx = d;
              p = n.y; d = n.dy; moveAxis(p, d, 1, YMAX); n.y = p; n.dy = d;
              n.div = 0;
            end else begin
              n.div = o.div + 1;
            end
          end
          if (o.rdy && va) begin
            n.waiting = 1'b1;
            n.px = (x > XMAX) ? XMAX : x;
            n.py = (y > YMAX) ? YMAX : y;
            n.pm = mo;
          end
        end
        n.rdy = !n.waiting && !n.dn;
        m[k] = n;
      end
    end
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual === expected) passes++;
    else $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
  endtask

  // One clock: drive inputs, advance the model, sample after the edge and compare both instances.
  task automatic applyStimulus(input bit r, input bit v, input bit va,
                               input logic [11:0] x, input logic [11:0] y, input bit mo);
    bit tk;
    rst = r; vs = v; valid = va; cx = x; cy = y; cm = mo;
    tk = v && !prevVs;
    prevVs = v;
    modelStep(r, tk, va, int'(x), int'(y), mo);
    @(posedge clk);
    @(negedge clk);
    checkOutput($sformatf("model_i0 t=%0t", $time), act0(), expOf(0));
    checkOutput($sformatf("model_i1 t=%0t", $time), act1(), expOf(1));
  endtask

  task automatic frame();
    applyStimulus(1'b0, 1'b1, 1'b0, 12'd0, 12'd0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 12'd0, 12'd0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 12'd0, 12'd0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 12'd0, 12'd0, 1'b0);
  endtask

  initial begin
    int  bx0[3], by0[3], bx1[3], by1[3];
    bit  rr, vsLvl, vv, mm;
    logic [11:0] rx, ry;

    rst = 1'b1; vs = 1'b0; valid = 1'b0; cx = '0; cy = '0; cm = 1'b0;

    // r, v, va, x, y, mo | eRdy, eDn, eX, eY, eB  (expected for the FRAME_DIV=1 instance)
    tbl[0] = '{1'b1, 1'b0, 1'b0, 12'd0,    12'd0,   1'b0, 1'b0, 1'b0, 12'd0,   12'd0,   1'b0};
    tbl[1] = '{1'b0, 1'b0, 1'b0, 12'd0,    12'd0,   1'b0, 1'b1, 1'b0, 12'd0,   12'd0,   1'b0};
    tbl[2] = '{1'b0, 1'b0, 1'b1, 12'd100,  12'd50,  1'b0, 1'b0, 1'b0, 12'd0,   12'd0,   1'b0};
    tbl[3] = '{1'b0, 1'b0, 1'b0, 12'd0,    12'd0,   1'b0, 1'b0, 1'b0, 12'd0,   12'd0,   1'b0};
    tbl[4] = '{1'b0, 1'b1, 1'b0, 12'd0,    12'd0,   1'b0, 1'b0, 1'b1, 12'd100, 12'd50,  1'b0};
    tbl[5] = '{1'b0, 1'b1, 1'b0, 12'd0,    12'd0,   1'b0, 1'b1, 1'b0, 12'd100, 12'd50,  1'b0};
    tbl[6] = '{1'b0, 1'b0, 1'b0, 12'd0,    12'd0,   1'b0, 1'b1, 1'b0, 12'd100, 12'd50,  1'b0};
    tbl[7] = '{1'b0, 1'b0, 1'b1, 12'd1000, 12'd700, 1'b0, 1'b0, 1'b0, 12'd100, 12'd50,  1'b0};
    tbl[8] = '{1'b0, 1'b1, 1'b0, 12'd0,    12'd0,   1'b0, 1'b0, 1'b1, 12'd384, 12'd120, 1'b0};
    tbl[9] = '{1'b0, 1'b0, 1'b0, 12'd0,    12'd0,   1'b0, 1'b1, 1'b0, 12'd384, 12'd120, 1'b0};

    for (int i = 0; i < 10; i++) begin
      applyStimulus(tbl[i].r, tbl[i].v, tbl[i].va, tbl[i].x, tbl[i].y, tbl[i].mo);
      checkOutput($sformatf("vec%0d", i), act0(),
                  {5'b0, tbl[i].eRdy, tbl[i].eDn, tbl[i].eB, tbl[i].eX, tbl[i].eY});
    end

    // Bounce from 380/119; the FRAME_DIV=3 instance moves only on every third tick.
    bx0 = '{382, 384, 382}; by0 = '{120, 119, 118};
    bx1 = '{380, 380, 382}; by1 = '{119, 119, 120};
    applyStimulus(1'b0, 1'b0, 1'b1, 12'd380, 12'd119, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b0, 12'd0, 12'd0, 1'b0);
    checkOutput("bounce_apply", act0(), pk(0, 1, 1, 380, 119));
    applyStimulus(1'b0, 1'b1, 1'b0, 12'd0, 12'd0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 12'd0, 12'd0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 12'd0, 12'd0, 1'b0);
    for (int f = 0; f < 3; f++) begin
      frame();
      checkOutput($sformatf("bounce_i0_f%0d", f), act0(), pk(1, 0, 1, bx0[f], by0[f]));
      checkOutput($sformatf("bounce_i1_f%0d", f), act1(), pk(1, 0, 1, bx1[f], by1[f]));
    end

    // Request arrives on the same cycle as a bounce tick.
    applyStimulus(1'b0, 1'b1, 1'b1, 12'd10, 12'd20, 1'b0);
    checkOutput("coinc_step", act0(), pk(0, 0, 1, 380, 117));
    applyStimulus(1'b0, 1'b1, 1'b0, 12'd0, 12'd0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 12'd0, 12'd0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 12'd0, 12'd0, 1'b0);
    checkOutput("coinc_wait", act0(), pk(0, 0, 1, 380, 117));
    applyStimulus(1'b0, 1'b1, 1'b0, 12'd0, 12'd0, 1'b0);
    checkOutput("coinc_apply", act0(), pk(0, 1, 0, 10, 20));
    applyStimulus(1'b0, 1'b0, 1'b0, 12'd0, 12'd0, 1'b0);
    checkOutput("coinc_idle", act0(), pk(1, 0, 0, 10, 20));

    // Reset while a request is pending, with VS already high as reset releases.
    applyStimulus(1'b0, 1'b0, 1'b1, 12'd200, 12'd100, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, 12'd0, 12'd0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, 12'd0, 12'd0, 1'b0);
    checkOutput("rst_pend", act0(), pk(0, 0, 0, 0, 0));
    applyStimulus(1'b0, 1'b1, 1'b0, 12'd0, 12'd0, 1'b0);
    checkOutput("rst_ready", act0(), pk(1, 0, 0, 0, 0));
    applyStimulus(1'b0, 1'b1, 1'b1, 12'd50, 12'd60, 1'b1);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 1'b0, 12'd0, 12'd0, 1'b0);
    checkOutput("vs_high_no_tick", act0(), pk(0, 0, 0, 0, 0));
    applyStimulus(1'b0, 1'b0, 1'b0, 12'd0, 12'd0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 12'd0, 12'd0, 1'b0);
    checkOutput("vs_rise_apply", act0(), pk(0, 1, 1, 50, 60));
    applyStimulus(1'b0, 1'b0, 1'b0, 12'd0, 12'd0, 1'b0);
    checkOutput("vs_rise_idle", act0(), pk(1, 0, 1, 50, 60));

    // Random traffic against the model.
    vsLvl = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      rr = ($urandom_range(0, 399) == 0);
      if ($urandom_range(0, 5) == 0) vsLvl = ~vsLvl;
      vv = ($urandom_range(0, 2) == 0);
      mm = ($urandom_range(0, 1) == 1);
      rx = 12'($urandom_range(0, 500));
      ry = 12'($urandom_range(0, 200));
      applyStimulus(rr, vsLvl, vv, rx, ry, mm);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
